// File: rtl/switch_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// sw_cond_pkg
//   Shared constants and types for the slide-switch conditioning path that
//   feeds the five-input majority voter.
//
//   SW_WIDTH                 number of switch bits (bit 4 = A ... bit 0 = E)
//   DEFAULT_SYNC_STAGES      synchroniser depth per bit (legal 2..4)
//   DEFAULT_DEBOUNCE_CYCLES  cycles a new level must persist (10 ms @ 100 MHz)
//   sw_bus_t                 the switch bus type
// -----------------------------------------------------------------------------
package sw_cond_pkg;

    localparam int SW_WIDTH                = 5;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef logic [SW_WIDTH-1:0] sw_bus_t;

endpackage : sw_cond_pkg

// File: rtl/switch_debouncer_if.sv
// -----------------------------------------------------------------------------
// switch_debouncer_if
//   Bundles the raw switch pins and the conditioned outputs of the debouncer.
//
//   sw_raw      raw, asynchronous switch pins        (master -> slave)
//   sw_clean    debounced switch levels              (slave -> master)
//   sw_changed  one-cycle strobe on any sw_clean change
//   sw_settled  high when no bit has a pending change
//   sw_rise     per-bit 0->1 acceptance pulse        (SWITCH_DEBOUNCER_EDGE_EN)
//   sw_fall     per-bit 1->0 acceptance pulse        (SWITCH_DEBOUNCER_EDGE_EN)
//
//   There is no valid/ready handshake on this bus: sw_clean is a level that is
//   always valid, and sw_changed marks the single cycle in which it moved.
//
//   Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN.
// -----------------------------------------------------------------------------
interface switch_debouncer_if #(
    parameter int WIDTH = sw_cond_pkg::SW_WIDTH
) ();

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic             sw_changed;
    logic             sw_settled;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
`endif

    // Master: the environment driving the pins and consuming the clean bus.
    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_changed,
        input  sw_settled
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        ,
        input  sw_rise,
        input  sw_fall
`endif
    );

    // Slave: the debouncer itself.
    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_changed,
        output sw_settled
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        ,
        output sw_rise,
        output sw_fall
`endif
    );

endinterface : switch_debouncer_if

// File: rtl/switch_debouncer_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   One switch bit: SYNC_STAGES-deep synchroniser, stability counter and the
//   clean output flop.
//
//   clk        system clock
//   rst        synchronous, active-high reset
//   raw_i      asynchronous switch pin
//   clean_o    debounced level
//   pending_o  counter non-zero (a change is being timed)
//   accept_o   combinational: clean_o takes the synchronised level at the
//              coming edge (lets the parent register strobes alongside it)
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic pending_o,
    output logic accept_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // Acceptance happens at DEBOUNCE_CYCLES-1, so the counter never wraps.
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   sync_lvl;
    logic                   accept;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        accept  = 1'b0;
        if (sync_lvl == clean_q) begin
            // Agreement (including a glitch returning) restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            clean_d = sync_lvl;
            cnt_d   = '0;
            accept  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o   = clean_q;
    assign pending_o = (cnt_q != '0);
    assign accept_o  = accept;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Conditions the five raw slide switches before the majority voter: each bit
//   is synchronised and debounced independently, and a single strobe marks any
//   change of the clean bus.
//
//   clk         system clock (rising edge)
//   rst         synchronous, active-high reset
//   bus.slave   switch_debouncer_if: sw_raw in; sw_clean, sw_changed,
//               sw_settled (and sw_rise/sw_fall) out
//
//   Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN adds per-bit registered
//   rise/fall pulses coincident with sw_changed.
// -----------------------------------------------------------------------------
module switch_debouncer
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    switch_debouncer_if.slave bus
);

    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] accept;

    logic changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (bus.sw_raw[i]),
            .clean_o   (clean[i]),
            .pending_o (pending[i]),
            .accept_o  (accept[i])
        );
    end

    // Any bit accepting at this edge means sw_clean changes at this edge; the
    // OR folds simultaneous acceptances into one strobe.
    assign changed_d = |accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // An accepting bit flips, so its old clean level tells the direction.
    assign rise_d = accept & ~clean;
    assign fall_d = accept &  clean;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.sw_rise = rise_q;
    assign bus.sw_fall = fall_q;
`endif

    assign bus.sw_clean   = clean;
    assign bus.sw_changed = changed_q;
    assign bus.sw_settled = ~|pending;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//   Directed bench for switch_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
//   (a clean change lands on the 6th edge after it is first sampled).
//   Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;
    import sw_cond_pkg::*;

    localparam int W  = SW_WIDTH;
    localparam int SS = 2;
    localparam int DC = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(W)) bus ();

    switch_debouncer #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step and count sw_changed pulses seen after each edge.
    task automatic step_count(input int n, inout int cnt);
        for (int k = 0; k < n; k++) begin
            step();
            if (bus.sw_changed) cnt++;
        end
    endtask

    function automatic logic majority(input logic [W-1:0] v);
        int ones = 0;
        for (int k = 0; k < W; k++) ones += int'(v[k]);
        return ones >= 3;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.sw_raw = 5'b10110;

        // Reset held with raw switches set.
        step_n(3);
        check("rst_clean",   {27'd0, bus.sw_clean}, 32'h00);
        check("rst_settled", {31'd0, bus.sw_settled}, 32'h1);
        check("rst_changed", {31'd0, bus.sw_changed}, 32'h0);

        // Release: acceptance on edge 6.
        rst = 1'b0;
        step_n(5);
        check("rel_e5_clean",   {27'd0, bus.sw_clean}, 32'h00);
        check("rel_e5_settled", {31'd0, bus.sw_settled}, 32'h0);
        step();
        check("rel_e6_clean",   {27'd0, bus.sw_clean}, 32'h16);
        check("rel_e6_changed", {31'd0, bus.sw_changed}, 32'h1);
        step();
        check("rel_e7_changed", {31'd0, bus.sw_changed}, 32'h0);
        check("rel_e7_settled", {31'd0, bus.sw_settled}, 32'h1);

        // Bouncy 0->1 on bit 0: 1,0,1,0 then hold 1.
        pulses = 0;
        bus.sw_raw[0] = 1'b1; step_count(1, pulses);
        bus.sw_raw[0] = 1'b0; step_count(1, pulses);
        bus.sw_raw[0] = 1'b1; step_count(1, pulses);
        bus.sw_raw[0] = 1'b0; step_count(1, pulses);
        bus.sw_raw[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step_count(1, pulses);
            check("bounce_hold", {31'd0, bus.sw_clean[0]}, 32'h0);
        end
        step_count(1, pulses);
        check("bounce_accept",  {27'd0, bus.sw_clean}, 32'h17);
        check("bounce_changed", {31'd0, bus.sw_changed}, 32'h1);
        step_count(1, pulses);
        check("bounce_pulses", pulses, 32'd1);

        // 3-cycle glitch on bit 3: must be rejected.
        pulses = 0;
        bus.sw_raw = 5'b11111;
        step_count(3, pulses);
        bus.sw_raw = 5'b10111;
        for (int i = 1; i <= 8; i++) begin
            step_count(1, pulses);
            if (i == 2) check("glitch_pending", {31'd0, bus.sw_settled}, 32'h0);
            if (i == 3) check("glitch_settled", {31'd0, bus.sw_settled}, 32'h1);
        end
        check("glitch_pulses", pulses, 32'd0);
        check("glitch_clean",  {27'd0, bus.sw_clean}, 32'h17);

        // Simultaneous 00000 -> 11100.
        bus.sw_raw = 5'b00000;
        step_n(8);
        check("simul_base", {27'd0, bus.sw_clean}, 32'h00);
        bus.sw_raw = 5'b11100;
        step_n(5);
        check("simul_early", {27'd0, bus.sw_clean}, 32'h00);
        step();
        check("simul_clean",    {27'd0, bus.sw_clean}, 32'h1C);
        check("simul_changed",  {31'd0, bus.sw_changed}, 32'h1);
        check("simul_majority", {31'd0, majority(bus.sw_clean)}, 32'h1);
        step();
        check("simul_strobe_1cyc", {31'd0, bus.sw_changed}, 32'h0);

        // Reset in the middle of a pending 0->1 on bit 2.
        bus.sw_raw = 5'b00000;
        step_n(8);
        check("midrst_base", {27'd0, bus.sw_clean}, 32'h00);
        bus.sw_raw = 5'b00100;
        step_n(4);
        check("midrst_pending", {31'd0, bus.sw_settled}, 32'h0);
        rst = 1'b1;
        step();
        check("midrst_clean",   {27'd0, bus.sw_clean}, 32'h00);
        check("midrst_settled", {31'd0, bus.sw_settled}, 32'h1);
        rst = 1'b0;
        step_n(5);
        check("midrst_e5", {27'd0, bus.sw_clean}, 32'h00);
        step();
        check("midrst_accept",  {27'd0, bus.sw_clean}, 32'h04);
        check("midrst_changed", {31'd0, bus.sw_changed}, 32'h1);

        // Bit 3 rises then falls.
        bus.sw_raw = 5'b01100;
        step_n(6);
        check("b3_rise_clean",   {27'd0, bus.sw_clean}, 32'h0C);
        check("b3_rise_changed", {31'd0, bus.sw_changed}, 32'h1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        check("b3_rise_vec", {27'd0, bus.sw_rise}, 32'h08);
        check("b3_rise_nofall", {27'd0, bus.sw_fall}, 32'h00);
`endif
        step();
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        check("b3_rise_1cyc", {27'd0, bus.sw_rise}, 32'h00);
`endif
        bus.sw_raw = 5'b00100;
        step_n(6);
        check("b3_fall_clean",   {27'd0, bus.sw_clean}, 32'h04);
        check("b3_fall_changed", {31'd0, bus.sw_changed}, 32'h1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        check("b3_fall_vec", {27'd0, bus.sw_fall}, 32'h08);
        check("b3_fall_norise", {27'd0, bus.sw_rise}, 32'h00);
`endif
        step();
        check("b3_fall_strobe_1cyc", {31'd0, bus.sw_changed}, 32'h0);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        check("b3_fall_1cyc", {27'd0, bus.sw_fall}, 32'h00);
`endif

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the five raw slide switches (ABCDE) before they reach the five-input majority voter.
- Synchronises each bit to clk, rejects contact bounce with a per-bit stability counter, and presents a clean 5-bit bus.
- Raises a one-cycle strobe whenever the clean bus changes, so downstream logic or display can sample on change.

Parameters:
- WIDTH, 5, number of switch bits (bit 4 = A … bit 0 = E).
- SYNC_STAGES, 2, flip-flops in each input synchroniser; legal range 2–4.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a new level must persist before it is accepted (10 ms at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous switch pins.
- sw_clean  output  WIDTH  debounced switch levels; connects to the voter's sw input.
- sw_changed  output  1  one-cycle strobe, high in the cycle sw_clean takes a new value.
- sw_settled  output  1  high when no bit has a pending change, i.e. all counters are zero.

Behaviour:
- Reset (rst high at a rising edge):
  - All synchroniser flops, counters, sw_clean and sw_changed clear to 0.
  - sw_settled goes to 1.
  - Reset mid-count discards any pending change.
- Synchroniser: a SYNC_STAGES-deep shift chain per bit; sync_q is the last stage.
- Counter width is $clog2(DEBOUNCE_CYCLES). Per bit, each edge:
  - If sync_q == sw_clean[i]: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: sw_clean[i] ← sync_q and counter ← 0.
  - Else: counter ← counter + 1.
- Glitch rejection: any return to the old level before acceptance zeroes the counter, and the full count restarts on the next disagreement.
- Latency: a clean raw level change appears on sw_clean at the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising edge, counting the first edge that samples the new raw value as edge 1.
- sw_changed is registered alongside sw_clean. It is high for exactly the one cycle in which sw_clean differs from its previous value.
- Several bits accepting on the same edge produce one strobe, not one per bit.
- sw_settled is combinational: NOR of all counter-nonzero flags.
- Bits are fully independent. There is no cross-bit ordering and no priority.
- Counters must never wrap, because acceptance occurs at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_EDGE_EN.
- Defined:
  - Adds output ports sw_rise [WIDTH-1:0] and sw_fall [WIDTH-1:0].
  - Each is a registered per-bit one-cycle pulse, coincident with sw_changed, marking a 0→1 or 1→0 acceptance on that bit.
  - Both clear to 0 on reset.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sw_cond_pkg holds:
  - SW_WIDTH = 5;
  - DEFAULT_SYNC_STAGES = 2;
  - DEFAULT_DEBOUNCE_CYCLES = 1000000;
  - typedef logic [SW_WIDTH-1:0] sw_bus_t.
- One sub-module, debounce_bit, contains the synchroniser chain, counter and clean flop for a single bit.
  - It exports its clean level and a pending flag (counter non-zero).
  - The top instantiates WIDTH copies with a generate loop and builds sw_changed and sw_settled from them.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, so latency = 6 edges):
- Reset release with sw_raw=5'b10110 held:
  - sw_clean=0 and sw_settled=1 during reset.
  - sw_clean=5'b10110 at edge 6 after release, with sw_changed high for that single cycle.
- Bouncy edge on bit 0: sw_raw[0] toggles 1,0,1,0 on successive edges, then holds 1:
  - sw_clean[0] stays 0 during the bounce.
  - sw_clean[0] becomes 1 exactly 6 edges after the final 0→1.
  - Exactly one sw_changed pulse.
- 3-cycle glitch: 0→1 held 3 edges, then back to 0:
  - sw_clean is unchanged and sw_changed never asserts.
  - sw_settled returns to 1 within 2 edges of the glitch reaching sync_q.
- Simultaneous change: sw_raw 5'b00000→5'b11100 on one edge:
  - All three bits update on the same edge with a single sw_changed pulse.
  - The voter fed from sw_clean then reads majority = 1.
- Reset mid-count: assert rst at edge 4 of a pending 0→1 on bit 2:
  - Counter cleared and sw_clean[2] remains 0.
  - After release, the change re-accepts 6 edges later.
- With SWITCH_DEBOUNCER_EDGE_EN: bit 3 accepts 0→1, then later 1→0:
  - sw_rise=5'b01000 for one cycle, then later sw_fall=5'b01000 for one cycle.
  - Both pulses coincide with sw_changed.
